// File: rtl/sudoku_pkg.sv
// Shared constants and FSM encoding for the sudoku hex-to-binary loader.
// Optional feature macro used by the loader: SUDOKU_H2B_ERR_EN (illegal-digit flag).
package sudoku_pkg;

    localparam int N         = 9;
    localparam int CELLS     = N * N;
    localparam int DIGW      = 4;
    localparam int CNTW      = 7;
    localparam int LAST_CELL = CELLS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sudoku_hex2onehot.sv
// Single-cell decoder: encoded digit to one-hot cell value.
// Digits 1..9 set bit d-1. Zero is an empty cell. Digits above 9 also decode
// to an empty cell, and they raise the illegal flag.
module sudoku_hex2onehot
    import sudoku_pkg::*;
(
    input  logic [DIGW-1:0] digit_i,
    output logic [N-1:0]    onehot_o,
    output logic            illegal_o
);

    // Decode one digit; anything outside 1..9 leaves the cell empty.
    always_comb begin
        onehot_o  = '0;
        illegal_o = (digit_i > DIGW'(9));
        if ((digit_i >= DIGW'(1)) && (digit_i <= DIGW'(9))) begin
            onehot_o = N'(1) << (digit_i - DIGW'(1));
        end
    end

endmodule

// File: rtl/sudoku_hex2bin_loader.sv
// Serial loader: takes one digit per handshake in cell order 0..80 and builds
// the 81-cell one-hot board consumed by the checker.
// Optional feature macro: SUDOKU_H2B_ERR_EN adds a sticky illegal-digit flag (err).
module sudoku_hex2bin_loader
    import sudoku_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIGW-1:0]      in_digit,
    output logic [CELLS*N-1:0]   bin,
    output logic                 busy,
    output logic                 done
`ifdef SUDOKU_H2B_ERR_EN
    ,
    output logic                 err
`endif
);

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [CELLS*N-1:0]   bin_q;
    logic [N-1:0]         cellOneHot;
    logic                 accept;

`ifdef SUDOKU_H2B_ERR_EN
    logic                 cellIllegal;
    logic                 err_q;

    assign err = err_q;
`else
    logic                 unusedIllegal;
`endif

    sudoku_hex2onehot u_dec (
        .digit_i   (in_digit),
        .onehot_o  (cellOneHot),
`ifdef SUDOKU_H2B_ERR_EN
        .illegal_o (cellIllegal)
`else
        .illegal_o (unusedIllegal)
`endif
    );

    // Outputs decode straight from the state register, so no input reaches an output combinationally.
    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign bin      = bin_q;

    // A digit is taken only while loading; start wins over any digit offered in the same cycle.
    assign accept = in_valid && (state_q == LOAD) && !start;

    // Next state and cell counter; the counter wraps to 0 when the last cell is taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (cnt_q == CNTW'(LAST_CELL)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State, counter and board registers; start clears the board, an accept writes cell cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
`ifdef SUDOKU_H2B_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                bin_q <= '0;
`ifdef SUDOKU_H2B_ERR_EN
                err_q <= 1'b0;
`endif
            end else if (accept) begin
                bin_q[int'(cnt_q) * N +: N] <= cellOneHot;
`ifdef SUDOKU_H2B_ERR_EN
                if (cellIllegal) begin
                    err_q <= 1'b1;
                end
`endif
            end
        end
    end

endmodule
